// File: rtl/uart_pkg.sv
// Shared constants, state encodings and baud divisor helper for the UART.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per oversample tick; truncates and never returns 0.
    function automatic int unsigned calc_div(input int unsigned f_hz, input int unsigned rate);
        int unsigned d;
        d = f_hz / (rate * OVERSAMPLE);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x-baud enable: enable16 high for one cycle every DIV cycles.
// Latency: first pulse in the cycle right after reset (counter starts at 0).
// Backpressure: none; consumers simply skip ticks they do not need.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned freq_hz = 100000000,
    parameter int unsigned baud    = 115200
) (
    input  logic clk,
    input  logic reset,
    output logic enable16
);

    localparam int unsigned DIV    = calc_div(freq_hz, baud);
    localparam int          CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count down from DIV-1; the tick fires while the counter sits at zero.
    always_comb begin
        enable16 = (cnt_q == '0);
        cnt_d    = enable16 ? RELOAD : cnt_q - CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART transceiver: 16x oversampled RX with flag registers, TX with busy flag.
// Latency: tx_busy/uart_txd react the cycle after tx_wr; rx_avail sets mid stop bit.
// Backpressure: tx_wr ignored while tx_busy; unacknowledged RX bytes are overwritten.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned freq_hz = 100000000,
    parameter int unsigned baud    = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_avail,
    output logic                 rx_error,
    input  logic                 rx_ack,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_busy
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    logic enable16;

    uart_baud_gen #(.freq_hz(freq_hz), .baud(baud)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .enable16 (enable16)
    );

    logic                 rxd_meta_q, rxd_sync_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [OSW-1:0]       rx_os_q, rx_os_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_avail_q, rx_avail_d;
    logic                 rx_error_q, rx_error_d;
    logic                 rx_done;

    tx_state_t            tx_state_q, tx_state_d;
    logic [OSW-1:0]       tx_os_q, tx_os_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;
    logic                 tx_busy_q, tx_busy_d;

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_avail_q <= 1'b0;
            rx_error_q <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_avail_q <= rx_avail_d;
            rx_error_q <= rx_error_d;
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // RX next state: find start edge, sample mid-bit every 16 ticks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_os_d  = '0;
                rx_bit_d = '0;
                if (!rxd_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (enable16) begin
                rx_os_d = rx_os_q + OSW'(1);
                if (rx_os_q == OS_MID) begin
                    // Counter restarts at mid start bit so later samples land mid-bit.
                    rx_os_d    = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: if (enable16) begin
                rx_os_d = rx_os_q + OSW'(1);
                if (rx_os_q == OS_LAST) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BW'(1);
                    if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: if (enable16) begin
                rx_os_d = rx_os_q + OSW'(1);
                if (rx_os_q == OS_LAST) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX next state: each of start/data/stop bits holds for 16 ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_os_d  = '0;
                tx_bit_d = '0;
                if (tx_wr) begin
                    tx_shift_d = tx_data;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (enable16) begin
                tx_os_d = tx_os_q + OSW'(1);
                if (tx_os_q == OS_LAST) tx_state_d = TX_DATA;
            end
            TX_DATA: if (enable16) begin
                tx_os_d = tx_os_q + OSW'(1);
                if (tx_os_q == OS_LAST) begin
                    tx_shift_d = {1'b1, tx_shift_q[DATA_BITS-1:1]};
                    tx_bit_d   = tx_bit_q + BW'(1);
                    if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: if (enable16) begin
                tx_os_d = tx_os_q + OSW'(1);
                if (tx_os_q == OS_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Outputs: RX flags (completion beats ack) and registered TX line/busy from next state.
    always_comb begin
        rx_done    = (rx_state_q == RX_STOP) && enable16 && (rx_os_q == OS_LAST);
        rx_data_d  = rx_data_q;
        rx_avail_d = rx_avail_q;
        rx_error_d = rx_error_q;
        if (rx_done) begin
            rx_data_d  = rx_shift_q;
            rx_avail_d = 1'b1;
            rx_error_d = ~rxd_sync_q;
        end else if (rx_ack) begin
            rx_avail_d = 1'b0;
            rx_error_d = 1'b0;
        end
        tx_busy_d = (tx_state_d != TX_IDLE);
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign uart_txd = txd_q;
    assign tx_busy  = tx_busy_q;
    assign rx_data  = rx_data_q;
    assign rx_avail = rx_avail_q;
    assign rx_error = rx_error_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at D=5 (bit period 80 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_core;

    localparam int BIT = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_busy;

    logic loop = 1'b0;
    logic drv_rxd = 1'b1;
    assign uart_rxd = loop ? uart_txd : drv_rxd;

    int errors = 0;
    int checks = 0;

    uart_core #(.freq_hz(100000000), .baud(1152000)) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_tx(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        cyc(1);
        tx_wr   = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
    endtask

    // which: 0 waits for rx_avail==level, 1 waits for tx_busy==level
    task automatic wait_for(input int which, input logic level, input int budget, output int n);
        n = 0;
        while (((which == 0) ? rx_avail : tx_busy) !== level && n < budget) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int stop_len);
        drv_rxd = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            drv_rxd = b[i];
            cyc(BIT);
        end
        drv_rxd = stop;
        cyc(stop_len);
        drv_rxd = 1'b1;
    endtask

    initial begin
        int n;
        int m;
        int lows;
        int avs;

        // Reset values
        cyc(3);
        reset = 1'b0;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_avail", 32'(rx_avail), 32'd0);
        check("rst_error", 32'(rx_error), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);

        // Loopback 0x55
        loop = 1'b1;
        cyc(2);
        strobe_tx(8'h55);
        check("lb_busy_rise", 32'(tx_busy), 32'd1);
        check("lb_start_bit", 32'(uart_txd), 32'd0);
        wait_for(0, 1'b1, 1000, n);
        check("lb_avail", 32'(rx_avail), 32'd1);
        check("lb_rx_latency_ok", 32'(n >= 740 && n <= 800), 32'd1);
        check("lb_data", 32'(rx_data), 32'h55);
        check("lb_error", 32'(rx_error), 32'd0);
        wait_for(1, 1'b0, 200, m);
        check("lb_busy_fall", 32'(tx_busy), 32'd0);
        check("lb_frame_len_ok", 32'(n + m >= 790 && n + m <= 810), 32'd1);
        check("lb_idle_txd", 32'(uart_txd), 32'd1);

        // Acknowledge clears flags, keeps data
        pulse_ack();
        check("ack_avail", 32'(rx_avail), 32'd0);
        check("ack_error", 32'(rx_error), 32'd0);
        check("ack_data", 32'(rx_data), 32'h55);

        // Framing error: 0xA3 with stop bit low
        loop = 1'b0;
        drive_frame(8'hA3, 1'b0, 55);
        cyc(100);
        check("fe_avail", 32'(rx_avail), 32'd1);
        check("fe_data", 32'(rx_data), 32'hA3);
        check("fe_error", 32'(rx_error), 32'd1);
        pulse_ack();
        check("fe_ack_avail", 32'(rx_avail), 32'd0);
        check("fe_ack_error", 32'(rx_error), 32'd0);

        // 3-cycle glitch must not produce a byte
        cyc(20);
        drv_rxd = 1'b0;
        cyc(3);
        drv_rxd = 1'b1;
        cyc(200);
        check("glitch_avail", 32'(rx_avail), 32'd0);
        check("glitch_error", 32'(rx_error), 32'd0);
        // RX back in idle: a clean frame is received normally
        drive_frame(8'h3C, 1'b1, BIT);
        cyc(2);
        check("post_glitch_avail", 32'(rx_avail), 32'd1);
        check("post_glitch_data", 32'(rx_data), 32'h3C);
        check("post_glitch_error", 32'(rx_error), 32'd0);
        pulse_ack();

        // Write while busy is dropped
        loop = 1'b1;
        cyc(5);
        strobe_tx(8'h12);
        cyc(100);
        strobe_tx(8'h34);
        check("busy_wr_busy", 32'(tx_busy), 32'd1);
        wait_for(0, 1'b1, 1000, n);
        check("busy_wr_avail", 32'(rx_avail), 32'd1);
        check("busy_wr_data", 32'(rx_data), 32'h12);
        pulse_ack();
        wait_for(1, 1'b0, 200, m);
        check("busy_wr_done", 32'(tx_busy), 32'd0);
        lows = 0;
        avs  = 0;
        for (int i = 0; i < 900; i++) begin
            cyc(1);
            if (uart_txd !== 1'b1) lows++;
            if (rx_avail !== 1'b0) avs++;
        end
        check("busy_wr_line_idle", 32'(lows), 32'd0);
        check("busy_wr_no_second", 32'(avs), 32'd0);

        // Reset in the middle of sending 0xFF
        loop = 1'b0;
        strobe_tx(8'hFF);
        cyc(300);
        check("midrst_busy_before", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrst_txd", 32'(uart_txd), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_avail", 32'(rx_avail), 32'd0);
        cyc(5);
        loop = 1'b1;
        cyc(2);
        strobe_tx(8'h0F);
        wait_for(0, 1'b1, 1000, n);
        check("after_rst_avail", 32'(rx_avail), 32'd1);
        check("after_rst_data", 32'(rx_data), 32'h0F);
        check("after_rst_error", 32'(rx_error), 32'd0);
        wait_for(1, 1'b0, 200, m);
        check("after_rst_busy", 32'(tx_busy), 32'd0);
        check("after_rst_txd", 32'(uart_txd), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
